dmem_bridge: RTL and testbench

Data-memory subsystem on the processor's memory-stage port. Decodes the memory-stage address into two word-addressed data RAM banks (scalar/vector, picked by `src_sel`) and a small memory-mapped I/O page. The I/O page holds a result-stream FIFO with a valid/ready output, a status register and a free-running cycle counter. Writes land on the clock edge; reads return combinationally in the same cycle, matching the pipeline's single-cycle memory stage.

---
 rtl/dmem_pkg.sv | 52 +++++
 rtl/dmem_bridge_fifo.sv | 83 ++++++++
 rtl/dmem_bridge.sv | 123 ++++++++++++
 tb/tb_dmem_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Purpose : shared constants, region enum and helpers for the data-memory bridge.
// Contents: I/O page addresses, status-word bit layout, region_t,
//           decode_region() (byte address -> region) and status_word().
package dmem_pkg;

  localparam logic [31:0] STREAM_ADDR = 32'h0001_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h0001_0004;
  localparam logic [31:0] CYCLE_ADDR  = 32'h0001_0008;

  // Status word layout: {16'b0, overflow, 7'b0, count[7:0]}
  localparam int STATUS_OVF_BIT = 15;
  localparam int STATUS_CNT_W   = 8;

  typedef enum logic [2:0] {
    RAM      = 3'd0,
    STREAM   = 3'd1,
    STATUS   = 3'd2,
    CYCLE    = 3'd3,
    UNMAPPED = 3'd4
  } region_t;

  // Decode on the word index only; the byte offset bits fall out of the shift.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_words);
    logic [31:0] word;
    region_t     rgn;
    word = addr >> 2;
    if (word < ram_words) begin
      rgn = RAM;
    end else if (word == (STREAM_ADDR >> 2)) begin
      rgn = STREAM;
    end else if (word == (STATUS_ADDR >> 2)) begin
      rgn = STATUS;
    end else if (word == (CYCLE_ADDR >> 2)) begin
      rgn = CYCLE;
    end else begin
      rgn = UNMAPPED;
    end
    return rgn;
  endfunction

  function automatic logic [31:0] status_word(input logic ovf,
                                             input logic [STATUS_CNT_W-1:0] cnt);
    logic [31:0] s;
    s = 32'h0000_0000;
    s[STATUS_OVF_BIT] = ovf;
    s[STATUS_CNT_W-1:0] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/dmem_bridge_fifo.sv
// sync_fifo
// Purpose : single-clock FIFO with combinational head (no fall-through).
// Ports   : clk, reset (sync, active-high)
//           push/din/full  - write side; push while full is taken if pop is high
//           pop/dout/empty - read side; dout is the oldest entry
//           count          - occupancy 0..DEPTH (one extra bit over the pointers)
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign empty = (count_q == (AW+1)'(0));
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok_s = push & (~full | pop_ok_s);

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; not reset, and a push during reset is discarded.
  always_ff @(posedge clk) begin
    if (!reset && push_ok_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge
// Purpose : memory-stage data port. Decodes aluoutM into two word-addressed
//           RAM banks (scalar/vector via src_sel) and an I/O page holding a
//           stream FIFO, a status register and a free-running cycle counter.
// Ports   : clk, reset (sync, active-high)
//           memwriteM, src_sel, aluoutM, writedataM - memory-stage request
//           readdataM                               - combinational load data
//           out_data, out_valid, out_ready          - stream FIFO output
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS  = 4096,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic        src_sel,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    ram_s_q [RAM_WORDS];
  logic [31:0]    ram_v_q [RAM_WORDS];
  logic [31:0]    cycle_q, cycle_d;
  logic           ovf_q, ovf_d;

  region_t        region_s;
  logic [RAW-1:0] ram_idx_s;
  logic           ram_we_s;
  logic           status_we_s;
  logic           fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [31:0]    fifo_dout_s;
  logic [CW-1:0]  fifo_count_s;
  logic           ovf_evt_s;

  assign region_s    = decode_region(aluoutM, 32'(RAM_WORDS));
  assign ram_idx_s   = aluoutM[RAW+1:2];
  assign ram_we_s    = memwriteM & (region_s == RAM);
  assign status_we_s = memwriteM & (region_s == STATUS);
  assign fifo_push_s = memwriteM & (region_s == STREAM);
  assign fifo_pop_s  = out_ready & ~fifo_empty_s;
  // A push is only lost when full and nothing leaves the same cycle.
  assign ovf_evt_s   = fifo_push_s & fifo_full_s & ~fifo_pop_s;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_s),
    .din   (writedataM),
    .full  (fifo_full_s),
    .pop   (fifo_pop_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign out_valid = ~fifo_empty_s;
  assign out_data  = fifo_dout_s;

  // Next-state for the sticky overflow flag (set beats clear) and cycle counter.
  always_comb begin
    ovf_d   = ovf_q;
    cycle_d = cycle_q + 32'd1;
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (status_we_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Status and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      cycle_q <= 32'd0;
    end else begin
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  // RAM banks; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      if (src_sel) begin
        ram_v_q[ram_idx_s] <= writedataM;
      end else begin
        ram_s_q[ram_idx_s] <= writedataM;
      end
    end
  end

  // Load mux; reads see pre-edge state, so a same-cycle store is not bypassed.
  always_comb begin
    readdataM = 32'h0000_0000;
    case (region_s)
      RAM: begin
        if (src_sel) begin
          readdataM = ram_v_q[ram_idx_s];
        end else begin
          readdataM = ram_s_q[ram_idx_s];
        end
      end
      STATUS:  readdataM = status_word(ovf_q, 8'(fifo_count_s));
      CYCLE:   readdataM = cycle_q;
      default: readdataM = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

  localparam logic [31:0] A_STREAM = 32'h0001_0000;
  localparam logic [31:0] A_STATUS = 32'h0001_0004;
  localparam logic [31:0] A_CYCLE  = 32'h0001_0008;

  logic        clk = 1'b0;
  logic        reset, memwriteM, src_sel, out_ready, out_valid;
  logic [31:0] aluoutM, writedataM, readdataM, out_data;

  int checks   = 0;
  int failures = 0;

  dmem_bridge #(.RAM_WORDS(4096), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwriteM  (memwriteM),
    .src_sel    (src_sel),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_ram0 [int];
  logic [31:0] m_ram1 [int];
  logic [31:0] m_q [$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_cyc = 32'd0;
  bit          m_ok  = 1'b0;

  // 0 RAM, 1 STREAM, 2 STATUS, 3 CYCLE, 4 unmapped
  function automatic int region_of(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    if (w < 4096) return 0;
    if (w == 32'h0000_4000) return 1;
    if (w == 32'h0000_4001) return 2;
    if (w == 32'h0000_4002) return 3;
    return 4;
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each rising edge using the inputs held across it.
  initial forever begin
    int  r;
    bit  pop, push, full;
    @(posedge clk);
    r = region_of(aluoutM);
    if (memwriteM && r == 0) begin
      if (src_sel) m_ram1[int'(aluoutM[13:2])] = writedataM;
      else         m_ram0[int'(aluoutM[13:2])] = writedataM;
    end
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'd0;
      m_ok  = 1'b1;
    end else begin
      pop  = (m_q.size() > 0) && out_ready;
      push = memwriteM && (r == 1);
      full = (m_q.size() == 8);
      if (push && full && !pop) m_ovf = 1'b1;
      else if (memwriteM && r == 2) m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push && !(full && !pop)) m_q.push_back(writedataM);
      m_cyc = m_cyc + 32'd1;
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  initial forever begin
    int          r, w;
    bit          known;
    logic [31:0] e;
    @(negedge clk);
    if (m_ok && !reset) begin
      r = region_of(aluoutM);
      known = 1'b1;
      e = 32'h0;
      w = int'(aluoutM[13:2]);
      case (r)
        0: begin
          if (src_sel) begin
            if (m_ram1.exists(w)) e = m_ram1[w]; else known = 1'b0;
          end else begin
            if (m_ram0.exists(w)) e = m_ram0[w]; else known = 1'b0;
          end
        end
        2: e = {16'h0, m_ovf, 7'h0, 8'(m_q.size())};
        3: e = m_cyc;
        default: e = 32'h0;
      endcase
      if (known) check32("model_readdata", readdataM, e);
      check32("model_out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() != 0)});
      if (m_q.size() != 0) check32("model_out_data", out_data, m_q[0]);
    end
  end

  task automatic drv(input logic we, input logic sel, input logic [31:0] a,
                     input logic [31:0] d, input logic rdy);
    memwriteM  = we;
    src_sel    = sel;
    aluoutM    = a;
    writedataM = d;
    out_ready  = rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] drain_exp [8];
  int          rp;
  int          pick;

  initial begin
    reset = 1'b1;
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick; tick;
    reset = 1'b0;

    // Reset state and cycle counter
    drv(1'b0, 1'b0, A_CYCLE, 32'h0, 1'b0);
    @(negedge clk);
    check32("cycle_at_0", readdataM, 32'd0);
    check32("reset_out_valid", {31'b0, out_valid}, 32'd0);
    tick;
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    @(negedge clk);
    check32("reset_status", readdataM, 32'h0000_0000);
    tick; tick; tick; tick;
    drv(1'b0, 1'b0, A_CYCLE, 32'h0, 1'b0);
    @(negedge clk);
    check32("cycle_at_5", readdataM, 32'd5);
    tick;

    // Bank isolation
    drv(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0); tick;
    drv(1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b0); tick;
    drv(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    @(negedge clk); check32("bank_scalar", readdataM, 32'hDEAD_BEEF); tick;
    drv(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    @(negedge clk); check32("bank_vector", readdataM, 32'h1234_5678); tick;

    // Back-to-back stores, same-cycle load sees old data
    drv(1'b1, 1'b0, 32'h20, 32'h1111_1111, 1'b0); tick;
    drv(1'b1, 1'b0, 32'h20, 32'h2222_2222, 1'b0);
    @(negedge clk); check32("store_no_bypass", readdataM, 32'h1111_1111); tick;
    drv(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    @(negedge clk); check32("store_visible", readdataM, 32'h2222_2222); tick;

    // Fill the FIFO, then overflow
    for (int i = 1; i <= 8; i++) begin
      drv(1'b1, 1'b0, A_STREAM, 32'(i), 1'b0); tick;
    end
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    @(negedge clk); check32("status_full", readdataM, 32'h0000_0008); tick;
    drv(1'b1, 1'b0, A_STREAM, 32'd9, 1'b0); tick;
    drv(1'b0, 1'b0, A_STREAM, 32'h0, 1'b0);
    @(negedge clk); check32("stream_read_zero", readdataM, 32'h0); tick;
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    @(negedge clk); check32("status_overflow", readdataM, 32'h0000_8008); tick;
    drv(1'b1, 1'b0, A_STATUS, 32'hFFFF_FFFF, 1'b0); tick;
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    @(negedge clk); check32("status_cleared", readdataM, 32'h0000_0008); tick;

    // Push into a full FIFO while popping
    drv(1'b1, 1'b0, A_STREAM, 32'hAA, 1'b1);
    @(negedge clk); check32("full_head", out_data, 32'd1); tick;
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    @(negedge clk); check32("full_pushpop_status", readdataM, 32'h0000_0008); tick;

    // Drain
    for (int k = 0; k < 7; k++) drain_exp[k] = 32'(k + 2);
    drain_exp[7] = 32'hAA;
    for (int k = 0; k < 8; k++) begin
      drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b1);
      @(negedge clk);
      check32("drain_valid", {31'b0, out_valid}, 32'd1);
      check32("drain_data", out_data, drain_exp[k]);
      tick;
    end
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b1);
    @(negedge clk);
    check32("drained_valid", {31'b0, out_valid}, 32'd0);
    check32("drained_status", readdataM, 32'h0);
    tick;

    // No fall-through, then push+pop with a single entry
    drv(1'b1, 1'b0, A_STREAM, 32'h0000_0C01, 1'b1);
    @(negedge clk); check32("no_fallthrough", {31'b0, out_valid}, 32'd0); tick;
    drv(1'b1, 1'b0, A_STREAM, 32'h0000_0C02, 1'b1);
    @(negedge clk); check32("single_head_old", out_data, 32'h0000_0C01); tick;
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    @(negedge clk);
    check32("single_head_new", out_data, 32'h0000_0C02);
    check32("single_status", readdataM, 32'h0000_0001);
    tick;
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b1); tick;

    // Reset with entries queued
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, A_STREAM, 32'(100 + i), 1'b0); tick;
    end
    reset = 1'b1;
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0); tick;
    reset = 1'b0;
    @(negedge clk);
    check32("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    check32("rst_mid_status", readdataM, 32'h0);
    tick;

    // Unmapped access
    drv(1'b1, 1'b0, 32'h0002_0000, 32'h5555_5555, 1'b0); tick;
    drv(1'b0, 1'b0, 32'h0002_0000, 32'h0, 1'b0);
    @(negedge clk); check32("unmapped_read", readdataM, 32'h0); tick;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rp = (n / 500) % 3 == 0 ? 10 : ((n / 500) % 3 == 1 ? 50 : 90);
      pick = int'($urandom_range(0, 11));
      case (pick)
        0, 1, 2, 3: aluoutM = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        4:          aluoutM = 32'h0000_3FFC;
        5, 10, 11:  aluoutM = A_STREAM;
        6:          aluoutM = A_STATUS;
        7:          aluoutM = A_CYCLE;
        8:          aluoutM = 32'h0000_4000;
        default:    aluoutM = 32'h0002_0000 | ($urandom & 32'h0000_FFFC);
      endcase
      memwriteM  = 1'($urandom_range(0, 1));
      src_sel    = 1'($urandom_range(0, 1));
      writedataM = $urandom;
      out_ready  = ($urandom_range(0, 99) < rp);
      reset      = ($urandom_range(0, 299) == 0);
      tick;
    end
    reset = 1'b0;
    drv(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
